// File: rtl/sram_responder.sv
// sram_responder: on-chip SRAM standing in for the PSRAM controller on the client handshake.
// Each accepted request holds o_busy for LATENCY+1 cycles, then completes and returns to idle.
module sram_responder #(
  parameter int unsigned ADDR_BITS     = 10,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        i_clkRAM,
  input  logic        reset,
  input  logic        i_cs,
  input  logic        i_write,
  input  logic [23:0] i_address,
  input  logic        i_bank,
  input  logic [7:0]  i_dataToWrite,
  output logic [7:0]  o_dataRead,
  output logic        o_busy,
  output logic        o_dataReady,
  output logic        o_addrErr
);

  localparam int unsigned Depth  = 2 * (2 ** ADDR_BITS);
  localparam logic [3:0]  RdLat  = 4'(READ_LATENCY);
  localparam logic [3:0]  WrLat  = 4'(WRITE_LATENCY);

  typedef enum logic {StIdle, StWait} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_run;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;
  logic             r_write;
  logic [ADDR_BITS:0] r_idx;
  logic [7:0]       r_wdata;
  logic [7:0]       r_data_read;
  logic             r_busy;
  logic             r_data_ready;
  logic             r_addr_err;
  logic [7:0]       w_rdata_next;
  logic             w_busy_next;
  logic             w_ready_next;
  logic             w_err_next;
  logic             w_accept;
  logic             w_done;
  logic             w_oor;
  logic [7:0]       r_mem [Depth];

  // Any set bit above the per-bank word address makes the request out of range.
  assign w_oor    = |(i_address >> ADDR_BITS);
  // r_run gates acceptance until one edge after reset release.
  assign w_accept = (r_state == StIdle) && r_run && !i_cs;
  assign w_done   = (r_state == StWait) && (r_cnt == 4'd0);

  assign o_dataRead  = r_data_read;
  assign o_busy      = r_busy;
  assign o_dataReady = r_data_ready;
  assign o_addrErr   = r_addr_err;

  // Reset-release synchronizer: first request accepted on the second edge after release.
  always_ff @(posedge i_clkRAM or negedge reset) begin
    if (!reset) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // State register.
  always_ff @(posedge i_clkRAM or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StWait;
      StWait:  if (r_cnt == 4'd0) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Next values of the counter and registered outputs.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_busy_next  = r_busy;
    w_ready_next = r_data_ready;
    w_err_next   = r_addr_err;
    w_rdata_next = r_data_read;
    if (w_accept) begin
      w_cnt_next   = i_write ? WrLat : RdLat;
      w_busy_next  = 1'b1;
      w_ready_next = 1'b0;
      w_err_next   = w_oor;
    end else if (r_state == StWait) begin
      if (r_cnt != 4'd0) begin
        w_cnt_next = r_cnt - 4'd1;
      end else begin
        w_busy_next = 1'b0;
        if (!r_write) begin
          w_ready_next = 1'b1;
          w_rdata_next = r_addr_err ? 8'hFF : r_mem[r_idx];
        end
      end
    end
  end

  // Counter, outputs and latched request fields.
  always_ff @(posedge i_clkRAM or negedge reset) begin
    if (!reset) begin
      r_cnt        <= 4'd0;
      r_busy       <= 1'b0;
      r_data_ready <= 1'b0;
      r_addr_err   <= 1'b0;
      r_data_read  <= 8'h00;
      r_write      <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= 8'h00;
    end else begin
      r_cnt        <= w_cnt_next;
      r_busy       <= w_busy_next;
      r_data_ready <= w_ready_next;
      r_addr_err   <= w_err_next;
      r_data_read  <= w_rdata_next;
      if (w_accept) begin
        r_write <= i_write;
        r_idx   <= {i_bank, i_address[ADDR_BITS-1:0]};
        r_wdata <= i_dataToWrite;
      end
    end
  end

  // Storage is not reset; an aborted write never reaches completion so leaves it untouched.
  always_ff @(posedge i_clkRAM) begin
    if (w_done && r_write && !r_addr_err) r_mem[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed and randomized requests checked against a byte-array model.
module tb_sram_responder;

  localparam int unsigned AB = 10;
  localparam int unsigned RL = 2;
  localparam int unsigned WL = 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs    = 1'b1;
  logic        wr    = 1'b0;
  logic        bank  = 1'b0;
  logic [23:0] addr  = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        busy;
  logic        ready;
  logic        aerr;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl_mem   [2 ** (AB + 1)];
  bit         mdl_valid [2 ** (AB + 1)];
  logic [7:0] mdl_rdata = 8'h00;
  bit         mdl_known = 1'b1;

  always #5 clk = ~clk;

  sram_responder #(
    .ADDR_BITS    (AB),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .i_clkRAM     (clk),
    .reset        (rst_n),
    .i_cs         (cs),
    .i_write      (wr),
    .i_address    (addr),
    .i_bank       (bank),
    .i_dataToWrite(wdata),
    .o_dataRead   (rdata),
    .o_busy       (busy),
    .o_dataReady  (ready),
    .o_addrErr    (aerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge where busy is seen low.
  // noisy: toggle i_cs and scramble the other inputs while waiting (must all be ignored).
  // hold: leave i_cs low afterwards so the next call is accepted back-to-back.
  task automatic do_req(input bit w, input logic [23:0] a, input bit b, input logic [7:0] d,
                        input bit noisy, input bit hold);
    int unsigned lat;
    bit          oor;
    int unsigned idx;
    int unsigned n;
    lat = w ? WL : RL;
    oor = (a >> AB) != 24'd0;
    idx = {b, a[AB-1:0]};
    cs = 1'b0; wr = w; addr = a; bank = b; wdata = d;
    @(negedge clk);
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_ready_clr", 32'(ready), 32'd0);
    chk("accept_err", 32'(aerr), 32'(oor));
    cs = 1'b1;
    n = 1;
    while (n <= 20) begin
      if (noisy) begin
        cs    = n[0] ? 1'b0 : 1'b1;
        wr    = 1'($urandom);
        addr  = 24'($urandom);
        bank  = 1'($urandom);
        wdata = 8'($urandom);
      end
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    cs = hold ? 1'b0 : 1'b1;
    chk("busy_len", n, lat + 1);
    chk("err_kept", 32'(aerr), 32'(oor));
    if (w) begin
      if (!oor) begin
        mdl_mem[idx]   = d;
        mdl_valid[idx] = 1'b1;
      end
      chk("wr_ready", 32'(ready), 32'd0);
      if (mdl_known) chk("wr_rdata_kept", 32'(rdata), 32'(mdl_rdata));
    end else begin
      chk("rd_ready", 32'(ready), 32'd1);
      if (oor) begin
        mdl_rdata = 8'hFF;
        mdl_known = 1'b1;
      end else begin
        mdl_known = mdl_valid[idx];
        mdl_rdata = mdl_mem[idx];
      end
      if (mdl_known) chk("rd_data", 32'(rdata), 32'(mdl_rdata));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_err"}, 32'(aerr), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'h00);
  endtask

  initial begin
    logic [9:0]  slot_lo [8];
    logic [7:0]  rd_byte;
    for (int i = 0; i < 2 ** (AB + 1); i++) mdl_valid[i] = 1'b0;

    // Reset values, then release and check the one-edge acceptance delay.
    #3;
    chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cs = 1'b0; wr = 1'b1; addr = 24'h000002; bank = 1'b0; wdata = 8'hA5;
    @(negedge clk);
    chk("rst_sync_wait", 32'(busy), 32'd0);

    // Write/read-back, bank isolation, out-of-range read.
    do_req(1'b1, 24'h000002, 1'b0, 8'hA5, 1'b0, 1'b0);
    do_req(1'b0, 24'h000002, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rab_a5", 32'(rdata), 32'hA5);
    do_req(1'b1, 24'h000010, 1'b0, 8'h11, 1'b0, 1'b0);
    do_req(1'b1, 24'h000010, 1'b1, 8'h22, 1'b0, 1'b0);
    do_req(1'b0, 24'h000010, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("bank0", 32'(rdata), 32'h11);
    do_req(1'b0, 24'h000010, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("bank1", 32'(rdata), 32'h22);
    do_req(1'b0, 24'h001002, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("oor_ff", 32'(rdata), 32'hFF);
    do_req(1'b1, 24'h001002, 1'b0, 8'h99, 1'b0, 1'b0);
    do_req(1'b0, 24'h000002, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("oor_no_write", 32'(rdata), 32'hA5);

    // Pulses on i_cs during a read's wait are ignored.
    do_req(1'b0, 24'h000010, 1'b1, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("no_extra_req", 32'(busy), 32'd0);

    // Reset one cycle into a write aborts it.
    do_req(1'b1, 24'h000020, 1'b0, 8'h3C, 1'b0, 1'b0);
    cs = 1'b0; wr = 1'b1; addr = 24'h000020; bank = 1'b0; wdata = 8'h5A;
    @(negedge clk);
    chk("abort_accept", 32'(busy), 32'd1);
    cs = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    mdl_rdata = 8'h00;
    mdl_known = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cs = 1'b0; wr = 1'b0; addr = 24'h000020; bank = 1'b0;
    @(negedge clk);
    chk("rst_sync_wait2", 32'(busy), 32'd0);
    do_req(1'b0, 24'h000020, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("abort_kept_3c", 32'(rdata), 32'h3C);

    // i_cs held low: back-to-back with one idle cycle each.
    do_req(1'b1, 24'h000030, 1'b0, 8'h77, 1'b0, 1'b1);
    do_req(1'b0, 24'h000030, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("hold_rd1", 32'(rdata), 32'h77);
    do_req(1'b0, 24'h000010, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("hold_rd2", 32'(rdata), 32'h22);
    do_req(1'b0, 24'h000002, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("hold_rd3", 32'(rdata), 32'hA5);

    // Randomized traffic over a small set of locations, some out of range.
    for (int i = 0; i < 8; i++) begin
      slot_lo[i] = 10'((i * 37 + 3) % 1024);
      do_req(1'b1, {14'd0, slot_lo[i]}, 1'b0, 8'($urandom), 1'b0, 1'b0);
      do_req(1'b1, {14'd0, slot_lo[i]}, 1'b1, 8'($urandom), 1'b0, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      logic [23:0] ra;
      ra = {14'd0, slot_lo[$urandom_range(0, 7)]};
      if ($urandom_range(0, 5) == 0) ra[23:10] = 14'($urandom_range(1, 16383));
      rd_byte = 8'($urandom);
      do_req(1'($urandom), ra, 1'($urandom), rd_byte, 1'($urandom),
             (i != 39) ? 1'($urandom) : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
